alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; power of two, 4..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port alu_op  input  4  opcode, sampled on accept.
REQ-007 SHALL have port operand_a  input  WIDTH  first operand, sampled on accept.
REQ-008 SHALL have port operand_b  input  WIDTH  second operand or shift amount, sampled on accept.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  WIDTH  primary result: sum, logic, shift, product low half or quotient.
REQ-012 SHALL have port result_hi  output  WIDTH  product high half or remainder; 0 for other ops.
REQ-013 SHALL have port flags  output  6  {illegal, div_zero, negative, zero, overflow, cout}, bit 0 = cout.

Function
REQ-014 SHALL use opcodes ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, SAR=7, MUL=8, DIV=9; 10..15 illegal.
REQ-015 SHALL implement states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL accept when in_valid & in_ready; the next state is BUSY for MUL, or for DIV with operand_b!=0, and DONE for all other ops.
REQ-017 SHALL make single-cycle ops (0..7, illegal, DIV by zero) valid exactly 1 cycle after accept.
REQ-018 SHALL compute MUL and DIV iteratively, one bit per cycle; BUSY lasts exactly WIDTH cycles, so out_valid rises WIDTH+1 cycles after accept.
REQ-019 SHALL hold result, result_hi and flags stable in DONE while out_ready=0.
REQ-020 SHALL return from DONE to IDLE when out_ready=1; no new accept in that same cycle, so sustained throughput is 1 op per 2 cycles minimum.
REQ-021 SHALL ignore out_ready outside DONE and in_valid outside IDLE.
REQ-022 ADD/SUB: WIDTH-bit two's complement; cout = carry out for ADD, borrow (a<b unsigned) for SUB.
REQ-023 ADD overflow = a,b same sign and result sign differs; SUB overflow = a,b signs differ and result sign differs from a.
REQ-024 AND/OR/XOR: cout=0, overflow=0.
REQ-025 Shifts: amount = operand_b[log2(WIDTH)-1:0], upper bits ignored; SAR sign-fills; cout = last bit shifted out, or 0 if amount=0; overflow=0.
REQ-026 MUL: unsigned product {result_hi,result}; overflow = (result_hi!=0); cout=0.
REQ-027 DIV: unsigned restoring division; result=quotient, result_hi=remainder; cout=0, overflow=0.
REQ-028 DIV by zero: result=all ones, result_hi=operand_a, div_zero=1, single cycle.
REQ-029 Illegal opcode: result=0, result_hi=0, illegal=1, all other flags 0.
REQ-030 zero = (result==0) and negative = result[WIDTH-1] for every op; result_hi does not affect them.

Reset
REQ-031 rst=1 SHALL force state IDLE on the next edge, including mid-BUSY or in DONE; the in-flight op is discarded.
REQ-032 After reset: in_ready=1, out_valid=0, result=0, result_hi=0, flags=0, iteration counter=0.
REQ-033 An accept is impossible in any cycle with rst=1.

Structure
REQ-034 Opcode constants and flag bit indices SHALL live in the shared opcodes header, extended with the new codes.
REQ-035 Iterative MUL/DIV datapath SHALL be sub-module alu_muldiv (start, op, a, b -> done, lo, hi); counter width log2(WIDTH)+1.
REQ-036 Combinational ops, flag generation and the FSM SHALL stay in alu_mc.

Verification (WIDTH=8)
REQ-037 ADD 0x7F+0x01 -> 1 cycle later out_valid, result=0x80, overflow=1, negative=1, cout=0.
REQ-038 SUB 0x80-0x01 -> result=0x7F, overflow=1, cout=0; SUB 0x01-0x02 -> result=0xFF, cout=1, overflow=0.
REQ-039 MUL 0xFF*0xFF, out_ready=0 for 3 cycles after out_valid -> valid on cycle 9 after accept, {hi,lo}=0xFE01, overflow=1, outputs stable until out_ready.
REQ-040 DIV 200/7 -> result=28, result_hi=4; DIV 5/0 -> 1 cycle later result=0xFF, result_hi=5, div_zero=1.
REQ-041 SAR 0x90 by operand_b=0x0B (amount 3) -> result=0xF2, cout=0; alu_op=12 -> illegal=1, result=0.
REQ-042 rst asserted on BUSY cycle 4 of MUL -> next cycle in_ready=1, out_valid=0; a following ADD 2+3 returns result=5.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for the multi-cycle ALU.
// Imported by alu_mc and its iterative multiply/divide datapath.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_SAR = 4'd7,
    OP_MUL = 4'd8,
    OP_DIV = 4'd9
  } alu_op_e;

  localparam int NUM_FLAGS     = 6;
  localparam int FLAG_COUT     = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_NEGATIVE = 3;
  localparam int FLAG_DIV_ZERO = 4;
  localparam int FLAG_ILLEGAL  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [NUM_FLAGS-1:0] pack_flags(
    input logic illegal,
    input logic div_zero,
    input logic negative,
    input logic zero,
    input logic overflow,
    input logic cout
  );
    logic [NUM_FLAGS-1:0] f;
    f                = '0;
    f[FLAG_ILLEGAL]  = illegal;
    f[FLAG_DIV_ZERO] = div_zero;
    f[FLAG_NEGATIVE] = negative;
    f[FLAG_ZERO]     = zero;
    f[FLAG_OVERFLOW] = overflow;
    f[FLAG_COUT]     = cout;
    return f;
  endfunction

  // MUL always iterates; DIV iterates only when there is a real divisor.
  function automatic logic is_iterative(input logic [3:0] op, input logic b_nonzero);
    return (op == OP_MUL) || ((op == OP_DIV) && b_nonzero);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// The first step is taken on the start edge, so done rises WIDTH-1 cycles after it.
module alu_muldiv
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             div_q, div_d;
  logic [CW-1:0]    count_q, count_d;
  logic             run_q, run_d;

  logic [WIDTH-1:0] src_lo, src_hi, src_b;
  logic             src_div;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   rshift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_lo, step_hi;

  // One iteration; on start it works straight from the port operands.
  always_comb begin
    if (start) begin
      src_hi  = '0;
      src_lo  = a;
      src_b   = b;
      src_div = (op == OP_DIV);
    end else begin
      src_hi  = hi_q;
      src_lo  = lo_q;
      src_b   = b_q;
      src_div = div_q;
    end

    msum   = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
    rshift = {src_hi, src_lo[WIDTH-1]};
    diff   = rshift - {1'b0, src_b};

    if (src_div) begin
      // Partial remainder stays below the divisor, so diff's top bit is the borrow.
      if (!diff[WIDTH]) begin
        step_hi = diff[WIDTH-1:0];
        step_lo = {src_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rshift[WIDTH-1:0];
        step_lo = {src_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = msum[WIDTH:1];
      step_lo = {msum[0], src_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    lo_d    = lo_q;
    hi_d    = hi_q;
    b_d     = b_q;
    div_d   = div_q;
    count_d = count_q;
    run_d   = run_q;
    if (start) begin
      lo_d    = step_lo;
      hi_d    = step_hi;
      b_d     = b;
      div_d   = (op == OP_DIV);
      count_d = CW'(1);
      run_d   = 1'b1;
    end else if (run_q && (count_q != LAST)) begin
      lo_d    = step_lo;
      hi_d    = step_hi;
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q    <= '0;
      hi_q    <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      count_q <= '0;
      run_q   <= 1'b0;
    end else begin
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      b_q     <= b_d;
      div_q   <= div_d;
      count_q <= count_d;
      run_q   <= run_d;
    end
  end

  assign done = run_q && (count_q == LAST);
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative MUL/DIV,
// with a valid/ready request side and a held result until the consumer takes it.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [5:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [5:0]       flags_q, flags_d;

  logic             accept;
  logic             md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [5:0]       md_flags;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w, sar_w;
  logic [WIDTH-1:0] fast_res, fast_hi;
  logic             fast_cout, fast_ovf, fast_dz, fast_ill;
  logic [5:0]       fast_flags;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready && !rst;
  assign shamt     = operand_b[SHW-1:0];

  // Shifts carry one guard bit so the last bit shifted out falls out as cout.
  always_comb begin
    add_w = {1'b0, operand_a} + {1'b0, operand_b};
    sub_w = {1'b0, operand_a} - {1'b0, operand_b};
    shl_w = {1'b0, operand_a} << shamt;
    shr_w = {operand_a, 1'b0} >> shamt;
    sar_w = $unsigned($signed({operand_a, 1'b0}) >>> shamt);

    fast_res  = '0;
    fast_hi   = '0;
    fast_cout = 1'b0;
    fast_ovf  = 1'b0;
    fast_dz   = 1'b0;
    fast_ill  = 1'b0;

    case (alu_op)
      OP_ADD: begin
        fast_res  = add_w[WIDTH-1:0];
        fast_cout = add_w[WIDTH];
        fast_ovf  = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                    (add_w[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        fast_res  = sub_w[WIDTH-1:0];
        fast_cout = sub_w[WIDTH];
        fast_ovf  = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                    (sub_w[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_AND: fast_res = operand_a & operand_b;
      OP_OR:  fast_res = operand_a | operand_b;
      OP_XOR: fast_res = operand_a ^ operand_b;
      OP_SHL: begin
        fast_res  = shl_w[WIDTH-1:0];
        fast_cout = shl_w[WIDTH];
      end
      OP_SHR: begin
        fast_res  = shr_w[WIDTH:1];
        fast_cout = shr_w[0];
      end
      OP_SAR: begin
        fast_res  = sar_w[WIDTH:1];
        fast_cout = sar_w[0];
      end
      OP_MUL: fast_res = '0;
      OP_DIV: begin
        fast_res = '1;
        fast_hi  = operand_a;
        fast_dz  = 1'b1;
      end
      default: fast_ill = 1'b1;
    endcase

    if (fast_ill) begin
      fast_flags = pack_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      fast_flags = pack_flags(1'b0, fast_dz, fast_res[WIDTH-1], (fast_res == '0),
                              fast_ovf, fast_cout);
    end
  end

  assign md_flags = pack_flags(1'b0, 1'b0, md_lo[WIDTH-1], (md_lo == '0),
                               (op_q == OP_MUL) && (md_hi != '0), 1'b0);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    md_start    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = alu_op;
          if (is_iterative(alu_op, operand_b != '0)) begin
            state_d  = ST_BUSY;
            md_start = 1'b1;
          end else begin
            state_d     = ST_DONE;
            result_d    = fast_res;
            result_hi_d = fast_hi;
            flags_d     = fast_flags;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          state_d     = ST_DONE;
          result_d    = md_lo;
          result_hi_d = md_hi;
          flags_d     = md_flags;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
    end
  end

  alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .start(md_start),
    .op   (alu_op),
    .a    (operand_a),
    .b    (operand_b),
    .done (md_done),
    .lo   (md_lo),
    .hi   (md_hi)
  );

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

endmodule
